// File: rtl/bcd_count_disp_if.sv
// Control/status bundle for the BCD counter and its seven-segment scan outputs.
// Combinational wiring only: no latency and no backpressure (every strobe is consumed).
interface bcd_count_disp_if;
    logic        slow_clk;
    logic        en;
    logic        up;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] count;
    logic        rollover;
    logic [3:0]  an;
    logic [6:0]  seg;

    modport master (
        output slow_clk, en, up, load, load_val,
        input  count, rollover, an, seg
    );

    modport slave (
        input  slow_clk, en, up, load, load_val,
        output count, rollover, an, seg
    );
endinterface

// File: rtl/bcd_count_disp.sv
// bcd_count_disp: 4-digit BCD up/down counter driving a multiplexed common-anode display.
// Latency: count/rollover one cycle after a tick or load, an/seg one cycle after sel; no backpressure, every event is taken.
module bcd_count_disp #(
    parameter int REFRESH_BITS = 17
) (
    input  logic              clk,
    input  logic              reset,
    bcd_count_disp_if.slave   bus
);

    logic                    slow_q, slow_d;
    logic [15:0]             count_q, count_d;
    logic                    rollover_q, rollover_d;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
    logic [3:0]              an_q, an_d;
    logic [6:0]              seg_q, seg_d;

    logic        tick;
    logic [15:0] load_clean;
    logic [15:0] step_val;
    logic        step_wrap;
    logic        carry;
    logic [1:0]  sel;
    logic [3:0]  digit;
    logic [3:0]  blank;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign slow_d = bus.slow_clk;
    assign tick   = bus.slow_clk & ~slow_q;

    always_comb begin
        load_clean = bus.load_val;
        for (int i = 0; i < 4; i++) begin
            if (bus.load_val[4*i +: 4] > 4'd9) begin
                load_clean[4*i +: 4] = 4'd0;
            end
        end
    end

    // Ripple carry/borrow; a carry out of digit 3 is the wrap condition.
    always_comb begin
        step_val = count_q;
        carry    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (bus.up) begin
                    if (count_q[4*i +: 4] == 4'd9) begin
                        step_val[4*i +: 4] = 4'd0;
                    end else begin
                        step_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                        carry              = 1'b0;
                    end
                end else begin
                    if (count_q[4*i +: 4] == 4'd0) begin
                        step_val[4*i +: 4] = 4'd9;
                    end else begin
                        step_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                        carry              = 1'b0;
                    end
                end
            end
        end
        step_wrap = carry;
    end

    always_comb begin
        count_d    = count_q;
        rollover_d = 1'b0;
        if (bus.load) begin
            count_d = load_clean;
        end else if (tick && bus.en) begin
            count_d    = step_val;
            rollover_d = step_wrap;
        end
    end

    assign blank[3] = (count_q[15:12] == 4'd0);
    assign blank[2] = blank[3] & (count_q[11:8] == 4'd0);
    assign blank[1] = blank[2] & (count_q[7:4]  == 4'd0);
    assign blank[0] = 1'b0;

    assign sel   = refresh_q[REFRESH_BITS-1 -: 2];
    assign digit = count_q[{sel, 2'b00} +: 4];

    // Anode and segments register from the same sel so they always change together.
    always_comb begin
        refresh_d = refresh_q + REFRESH_BITS'(1);
        an_d      = ~(4'b0001 << sel);
        seg_d     = blank[sel] ? 7'b1111111 : seg7(digit);
    end

    always_ff @(posedge clk) begin
        slow_q <= slow_d;
        if (!reset) begin
            count_q    <= 16'h0000;
            rollover_q <= 1'b0;
            refresh_q  <= '0;
            an_q       <= 4'b1111;
            seg_q      <= 7'b1111111;
        end else begin
            count_q    <= count_d;
            rollover_q <= rollover_d;
            refresh_q  <= refresh_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.rollover = rollover_q;
    assign bus.an       = an_q;
    assign bus.seg      = seg_q;

endmodule

// File: doc/bcd_count_disp.md
# bcd_count_disp

Four-digit BCD up/down counter with a multiplexed seven-segment driver. Sits directly downstream of the display clock divider and consumes its `slow_clk` output as a count-enable strobe (edge-detected, single clock domain). It drives the board's common-anode four-digit display.

## Interface
- `REFRESH_BITS`, 17: width of the free-running scan counter; its top 2 bits select the active digit.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-low; the block is reset when `reset`=0 at a `clk` rising edge.
- `slow_clk`  in  1  level from the clock divider, synchronous to `clk`; each rising edge is one count event.
- `en`  in  1  count enable; count events are ignored when 0.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  16  four BCD digits; [3:0] is digit 0, the rightmost digit.
- `count`  out  16  current BCD value, registered.
- `rollover`  out  1  one-cycle pulse on a 9999→0000 or 0000→9999 wrap.
- `an`  out  4  digit anodes, active-low; `an[0]` drives digit 0.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.

## Operation
- Edge detect:
  - `slow_q` is a register that samples `slow_clk` every cycle, including while reset is asserted.
  - `tick = slow_clk & ~slow_q`.
  - Because `slow_q` samples during reset, a `slow_clk` already high at reset release produces no tick.
- Counter update priority, evaluated each cycle:
  - reset first.
  - then `load`: `count <= load_val`. Any nibble greater than 9 loads as 0. A tick in the same cycle is discarded.
  - then `tick & en`: increment or decrement by one with BCD ripple carry/borrow across all four digits.
  - otherwise hold.
- Wrap:
  - up from 9999 gives 0000; down from 0000 gives 9999.
  - `rollover` is 1 in the cycle following the wrap update only. A load never pulses `rollover`.
- Scan:
  - `refresh` is a `REFRESH_BITS`-bit free-running counter that wraps to 0.
  - `sel = refresh[REFRESH_BITS-1 -: 2]`. `sel`=k selects digit k and drives `an` with only bit k low.
- Leading-zero blanking:
  - Digit k (k≥1) is blanked (`seg`=1111111, anode still driven) if it and every higher digit are 0.
  - Digit 0 is never blanked.
- Segment decode for digits 0–9 ({g..a}, active-low): 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Reset values: `count`=0000, `rollover`=0, `refresh`=0, `an`=1111, `seg`=1111111.
- Reset asserted mid-count overrides `load` and ticks in the same cycle.

## Timing
- A `slow_clk` rise seen in cycle N updates `count` at the end of cycle N, so it is visible in N+1.
- `rollover` is high during cycle N+1 only.
- `load` asserted in cycle N makes `count = load_val` visible in N+1.
- `an` and `seg` lag `sel` by one cycle and update together; there is no cycle where the new anode is shown with the old segments.
- After reset release, `an` first goes active on the second cycle: `an`=1110 with digit 0's pattern.
- One digit period is 2^(REFRESH_BITS-2) cycles. The full scan period is 2^REFRESH_BITS cycles.
- `slow_clk` high for many cycles produces exactly one count event. Back-to-back edges need `slow_clk` low for at least one cycle between them.

## Test plan
- Reset then hold:
  - Stimulus: `reset`=0 for 3 cycles with `slow_clk`=1, then release and hold `slow_clk`=1.
  - Required: `count`=0000, `an`=1111, `seg`=1111111 during reset; no tick after release.
- Up count:
  - Stimulus: `en`=1, `up`=1, 10 `slow_clk` pulses from 0000.
  - Required: `count`=0010; the 0009→0010 carry is correct; `rollover` is never high.
- Wrap:
  - Stimulus: load 9999, one up tick; then load 0000, one down tick.
  - Required: 0000 then 9999; `rollover` pulses for exactly 1 cycle each time.
- Load vs tick:
  - Stimulus: `load`=1, `load_val`=0x12A4 in the same cycle as a tick edge.
  - Required: `count`=0x1204 (nibble A loads as 0); tick discarded; no `rollover`.
- Scan with `REFRESH_BITS`=4 and `count`=0x0305:
  - Required: `an` cycles 1110→1101→1011→0111, 4 cycles each.
  - Required `seg`: digit 0 = 0010010, digit 1 = 1000000, digit 2 = 0110000, digit 3 = 1111111 (blanked).
- Reset mid-operation:
  - Stimulus: `reset`=0 coincident with a tick and `load`.
  - Required: `count`=0000 and `rollover`=0 next cycle; counting resumes from 0000 on the next `slow_clk` edge after release.
